// File: rtl/rvfi_commit_packer.sv
// Packs up to LANES ROB commits per cycle into the first channels of a registered
// RVFI-style monitor bundle. It numbers retirements and flags halt and protocol violations.
module rvfi_commit_packer #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned CHANNELS = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [LANES-1:0]                 in_valid,
  input  logic [LANES-1:0][31:0]           in_inst,
  input  logic [LANES-1:0][31:0]           in_pc_rdata,
  input  logic [LANES-1:0][31:0]           in_pc_wdata,
  input  logic [LANES-1:0][4:0]            in_rs1_addr,
  input  logic [LANES-1:0][4:0]            in_rs2_addr,
  input  logic [LANES-1:0][4:0]            in_rd_addr,
  input  logic [LANES-1:0][31:0]           in_rs1_rdata,
  input  logic [LANES-1:0][31:0]           in_rs2_rdata,
  input  logic [LANES-1:0][31:0]           in_rd_wdata,
  input  logic [LANES-1:0][31:0]           in_mem_addr,
  input  logic [LANES-1:0][31:0]           in_mem_rdata,
  input  logic [LANES-1:0][31:0]           in_mem_wdata,
  input  logic [LANES-1:0][3:0]            in_mem_rmask,
  input  logic [LANES-1:0][3:0]            in_mem_wmask,
  output logic [CHANNELS-1:0]              mon_valid,
  output logic [CHANNELS-1:0][63:0]        mon_order,
  output logic [CHANNELS-1:0]              mon_halt,
  output logic [CHANNELS-1:0][31:0]        mon_inst,
  output logic [CHANNELS-1:0][31:0]        mon_pc_rdata,
  output logic [CHANNELS-1:0][31:0]        mon_pc_wdata,
  output logic [CHANNELS-1:0][4:0]         mon_rs1_addr,
  output logic [CHANNELS-1:0][4:0]         mon_rs2_addr,
  output logic [CHANNELS-1:0][4:0]         mon_rd_addr,
  output logic [CHANNELS-1:0][31:0]        mon_rs1_rdata,
  output logic [CHANNELS-1:0][31:0]        mon_rs2_rdata,
  output logic [CHANNELS-1:0][31:0]        mon_rd_wdata,
  output logic [CHANNELS-1:0][31:0]        mon_mem_addr,
  output logic [CHANNELS-1:0][31:0]        mon_mem_rdata,
  output logic [CHANNELS-1:0][31:0]        mon_mem_wdata,
  output logic [CHANNELS-1:0][3:0]         mon_mem_rmask,
  output logic [CHANNELS-1:0][3:0]         mon_mem_wmask,
  output logic                             halted,
  output logic                             error
);

  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned KW = $clog2(CHANNELS + 1);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
  } rec_t;

  rec_t [CHANNELS-1:0]       ch_d, ch_q;
  logic [CHANNELS-1:0]       valid_d, valid_q;
  logic [CHANNELS-1:0]       halt_d, halt_q;
  logic [CHANNELS-1:0][63:0] order_d, order_q;
  logic [63:0]               order_cnt_d, order_cnt_q;
  logic                      halted_d, halted_q;
  logic                      error_d, error_q;

  logic [KW-1:0] k;
  logic [CW-1:0] idx;
  logic          stop;
  logic          err;
  logic          halt_seen;

  // Walk lanes oldest-first; k counts forwarded lanes and doubles as the target channel.
  // Once a halt is forwarded (or already halted), any further valid lane is dropped as an error.
  always_comb begin
    ch_d        = '0;
    valid_d     = '0;
    halt_d      = '0;
    order_d     = '0;
    k           = '0;
    idx         = '0;
    stop        = halted_q;
    err         = 1'b0;
    halt_seen   = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (in_valid[l]) begin
        if (stop) begin
          err = 1'b1;
        end else begin
          idx                = k[CW-1:0];
          valid_d[idx]       = 1'b1;
          order_d[idx]       = order_cnt_q + 64'(k);
          halt_d[idx]        = (in_pc_wdata[l] == in_pc_rdata[l]);
          ch_d[idx].inst      = in_inst[l];
          ch_d[idx].pc_rdata  = in_pc_rdata[l];
          ch_d[idx].pc_wdata  = in_pc_wdata[l];
          ch_d[idx].rs1_addr  = in_rs1_addr[l];
          ch_d[idx].rs2_addr  = in_rs2_addr[l];
          ch_d[idx].rd_addr   = in_rd_addr[l];
          ch_d[idx].rs1_rdata = in_rs1_rdata[l];
          ch_d[idx].rs2_rdata = in_rs2_rdata[l];
          ch_d[idx].rd_wdata  = in_rd_wdata[l];
          ch_d[idx].mem_addr  = in_mem_addr[l];
          ch_d[idx].mem_rdata = in_mem_rdata[l];
          ch_d[idx].mem_wdata = in_mem_wdata[l];
          ch_d[idx].mem_rmask = in_mem_rmask[l];
          ch_d[idx].mem_wmask = in_mem_wmask[l];
          if (in_rd_addr[l] == '0 && in_rd_wdata[l] != '0) err = 1'b1;
          if (in_mem_rmask[l] != '0 && in_mem_wmask[l] != '0) err = 1'b1;
          if (halt_d[idx]) begin
            stop      = 1'b1;
            halt_seen = 1'b1;
          end
          k = k + 1'b1;
        end
      end
    end
    order_cnt_d = order_cnt_q + 64'(k);
    halted_d    = halted_q | halt_seen;
    error_d     = error_q | err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q        <= '0;
      valid_q     <= '0;
      halt_q      <= '0;
      order_q     <= '0;
      order_cnt_q <= '0;
      halted_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      ch_q        <= ch_d;
      valid_q     <= valid_d;
      halt_q      <= halt_d;
      order_q     <= order_d;
      order_cnt_q <= order_cnt_d;
      halted_q    <= halted_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    mon_valid = valid_q;
    mon_halt  = halt_q;
    mon_order = order_q;
    halted    = halted_q;
    error     = error_q;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      mon_inst[c]      = ch_q[c].inst;
      mon_pc_rdata[c]  = ch_q[c].pc_rdata;
      mon_pc_wdata[c]  = ch_q[c].pc_wdata;
      mon_rs1_addr[c]  = ch_q[c].rs1_addr;
      mon_rs2_addr[c]  = ch_q[c].rs2_addr;
      mon_rd_addr[c]   = ch_q[c].rd_addr;
      mon_rs1_rdata[c] = ch_q[c].rs1_rdata;
      mon_rs2_rdata[c] = ch_q[c].rs2_rdata;
      mon_rd_wdata[c]  = ch_q[c].rd_wdata;
      mon_mem_addr[c]  = ch_q[c].mem_addr;
      mon_mem_rdata[c] = ch_q[c].mem_rdata;
      mon_mem_wdata[c] = ch_q[c].mem_wdata;
      mon_mem_rmask[c] = ch_q[c].mem_rmask;
      mon_mem_wmask[c] = ch_q[c].mem_wmask;
    end
  end

endmodule

// File: tb/tb_rvfi_commit_packer.sv
// Directed self-checking bench for rvfi_commit_packer at LANES=2, CHANNELS=8.
module tb_rvfi_commit_packer;
  localparam int unsigned LANES    = 2;
  localparam int unsigned CHANNELS = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [LANES-1:0]          in_valid;
  logic [LANES-1:0][31:0]    in_inst, in_pc_rdata, in_pc_wdata;
  logic [LANES-1:0][4:0]     in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [LANES-1:0][31:0]    in_rs1_rdata, in_rs2_rdata, in_rd_wdata;
  logic [LANES-1:0][31:0]    in_mem_addr, in_mem_rdata, in_mem_wdata;
  logic [LANES-1:0][3:0]     in_mem_rmask, in_mem_wmask;
  logic [CHANNELS-1:0]       mon_valid, mon_halt;
  logic [CHANNELS-1:0][63:0] mon_order;
  logic [CHANNELS-1:0][31:0] mon_inst, mon_pc_rdata, mon_pc_wdata;
  logic [CHANNELS-1:0][4:0]  mon_rs1_addr, mon_rs2_addr, mon_rd_addr;
  logic [CHANNELS-1:0][31:0] mon_rs1_rdata, mon_rs2_rdata, mon_rd_wdata;
  logic [CHANNELS-1:0][31:0] mon_mem_addr, mon_mem_rdata, mon_mem_wdata;
  logic [CHANNELS-1:0][3:0]  mon_mem_rmask, mon_mem_wmask;
  logic halted, error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rvfi_commit_packer #(.LANES(LANES), .CHANNELS(CHANNELS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_inst(in_inst), .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_rs1_rdata(in_rs1_rdata), .in_rs2_rdata(in_rs2_rdata), .in_rd_wdata(in_rd_wdata),
    .in_mem_addr(in_mem_addr), .in_mem_rdata(in_mem_rdata), .in_mem_wdata(in_mem_wdata),
    .in_mem_rmask(in_mem_rmask), .in_mem_wmask(in_mem_wmask),
    .mon_valid(mon_valid), .mon_order(mon_order), .mon_halt(mon_halt),
    .mon_inst(mon_inst), .mon_pc_rdata(mon_pc_rdata), .mon_pc_wdata(mon_pc_wdata),
    .mon_rs1_addr(mon_rs1_addr), .mon_rs2_addr(mon_rs2_addr), .mon_rd_addr(mon_rd_addr),
    .mon_rs1_rdata(mon_rs1_rdata), .mon_rs2_rdata(mon_rs2_rdata), .mon_rd_wdata(mon_rd_wdata),
    .mon_mem_addr(mon_mem_addr), .mon_mem_rdata(mon_mem_rdata), .mon_mem_wdata(mon_mem_wdata),
    .mon_mem_rmask(mon_mem_rmask), .mon_mem_wmask(mon_mem_wmask),
    .halted(halted), .error(error)
  );

  task automatic clear_inputs();
    in_valid = '0;
    in_inst = '0; in_pc_rdata = '0; in_pc_wdata = '0;
    in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
    in_rs1_rdata = '0; in_rs2_rdata = '0; in_rd_wdata = '0;
    in_mem_addr = '0; in_mem_rdata = '0; in_mem_wdata = '0;
    in_mem_rmask = '0; in_mem_wmask = '0;
  endtask

  // Lane contents derived from a seed so expected monitor fields are easy to recompute.
  task automatic set_lane(input int unsigned l, input logic [31:0] s);
    in_inst[l]      = 32'hA000_0000 | s;
    in_pc_rdata[l]  = 32'h8000_0000 + (s << 2);
    in_pc_wdata[l]  = 32'h8000_0004 + (s << 2);
    in_rs1_addr[l]  = 5'd1;
    in_rs2_addr[l]  = 5'd2;
    in_rd_addr[l]   = 5'd3;
    in_rs1_rdata[l] = s + 32'd1;
    in_rs2_rdata[l] = s + 32'd2;
    in_rd_wdata[l]  = s + 32'd3;
    in_mem_addr[l]  = s + 32'd4;
    in_mem_rmask[l] = 4'h0;
    in_mem_wmask[l] = 4'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    set_lane(0, 1); set_lane(1, 2);
    in_valid = 2'b11;
    rst = 1'b0;
    tick(); tick();
    checks++; if (mon_valid !== '0) begin errors++; $display("FAIL reset_valid: got %h want 0", mon_valid); end
    checks++; if (mon_order !== '0) begin errors++; $display("FAIL reset_order: got nonzero %h want 0", mon_order[0]); end
    checks++; if (mon_halt !== '0 || halted !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got halt=%h halted=%b error=%b want 0", mon_halt, halted, error);
    end
    rst = 1'b1;
    tick();
    checks++; if (mon_valid !== 8'h03) begin errors++; $display("FAIL release_valid: got %h want 03", mon_valid); end
    checks++; if (mon_order[0] !== 64'd0 || mon_order[1] !== 64'd1) begin
      errors++; $display("FAIL release_order: got %0d,%0d want 0,1", mon_order[0], mon_order[1]);
    end
  endtask

  task automatic test_two_lanes();
    logic [31:0] s0, s1;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      s0 = 32'd10 + 32'(2 * c);
      s1 = s0 + 32'd1;
      set_lane(0, s0); set_lane(1, s1);
      in_valid = 2'b11;
      tick();
      checks++; if (mon_valid !== 8'h03) begin errors++; $display("FAIL two_lanes_valid c%0d: got %h want 03", c, mon_valid); end
      checks++; if (mon_order[0] !== 64'(2 * c) || mon_order[1] !== 64'(2 * c + 1)) begin
        errors++; $display("FAIL two_lanes_order c%0d: got %0d,%0d want %0d,%0d", c, mon_order[0], mon_order[1], 2 * c, 2 * c + 1);
      end
      checks++; if (mon_inst[0] !== (32'hA000_0000 | s0) || mon_rd_wdata[1] !== s1 + 32'd3 || mon_mem_addr[1] !== s1 + 32'd4) begin
        errors++; $display("FAIL two_lanes_data c%0d: got %h/%h/%h", c, mon_inst[0], mon_rd_wdata[1], mon_mem_addr[1]);
      end
      checks++; if (error !== 1'b0 || mon_halt !== '0) begin errors++; $display("FAIL two_lanes_err c%0d: got err=%b halt=%h want 0", c, error, mon_halt); end
    end
  endtask

  // Continues from order_cnt=6 left by test_two_lanes.
  task automatic test_compact();
    set_lane(0, 99); set_lane(1, 40);
    in_valid = 2'b10;
    tick();
    checks++; if (mon_valid !== 8'h01) begin errors++; $display("FAIL compact_valid: got %h want 01", mon_valid); end
    checks++; if (mon_order[0] !== 64'd6 || mon_order[1] !== 64'd0) begin
      errors++; $display("FAIL compact_order: got %0d,%0d want 6,0", mon_order[0], mon_order[1]);
    end
    checks++; if (mon_inst[0] !== 32'hA000_0028 || mon_pc_wdata[0] !== 32'h8000_00A4) begin
      errors++; $display("FAIL compact_data: got %h/%h want a0000028/800000a4", mon_inst[0], mon_pc_wdata[0]);
    end
    in_valid = 2'b00;
    tick();
    checks++; if (mon_valid !== '0 || mon_order !== '0) begin errors++; $display("FAIL idle_zero: got valid=%h order0=%0d want 0", mon_valid, mon_order[0]); end
    set_lane(0, 50);
    in_valid = 2'b01;
    tick();
    checks++; if (mon_valid !== 8'h01 || mon_order[0] !== 64'd7) begin
      errors++; $display("FAIL compact_next_order: got valid=%h order=%0d want 01/7", mon_valid, mon_order[0]);
    end
  endtask

  task automatic test_halt();
    do_reset();
    set_lane(0, 1); set_lane(1, 2);
    in_pc_rdata[0] = 32'h6000_0040;
    in_pc_wdata[0] = 32'h6000_0040;
    in_valid = 2'b11;
    tick();
    checks++; if (mon_valid !== 8'h01 || mon_halt !== 8'h01) begin
      errors++; $display("FAIL halt_fwd: got valid=%h halt=%h want 01/01", mon_valid, mon_halt);
    end
    checks++; if (mon_order[0] !== 64'd0 || mon_pc_rdata[0] !== 32'h6000_0040) begin
      errors++; $display("FAIL halt_data: got order=%0d pc=%h want 0/60000040", mon_order[0], mon_pc_rdata[0]);
    end
    checks++; if (error !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL halt_flags: got err=%b halted=%b want 1/1", error, halted); end
    set_lane(0, 3); set_lane(1, 4);
    in_valid = 2'b01;
    tick();
    checks++; if (mon_valid !== '0) begin errors++; $display("FAIL halted_drop: got %h want 0", mon_valid); end
    checks++; if (dut.order_cnt_q !== 64'd1) begin errors++; $display("FAIL halted_cnt: got %0d want 1", dut.order_cnt_q); end
    in_valid = 2'b00;
    tick(); tick();
    checks++; if (error !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL halted_sticky: got err=%b halted=%b want 1/1", error, halted); end
  endtask

  task automatic test_rd0();
    do_reset();
    set_lane(0, 7);
    in_rd_addr[0] = 5'd0; in_rd_wdata[0] = 32'd0;
    in_valid = 2'b01;
    tick();
    checks++; if (mon_valid !== 8'h01 || error !== 1'b0) begin errors++; $display("FAIL rd0_zero: got valid=%h err=%b want 01/0", mon_valid, error); end
    in_rd_wdata[0] = 32'h0000_0005;
    tick();
    checks++; if (mon_valid !== 8'h01 || mon_rd_wdata[0] !== 32'd5) begin
      errors++; $display("FAIL rd0_fwd: got valid=%h wdata=%h want 01/5", mon_valid, mon_rd_wdata[0]);
    end
    checks++; if (error !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL rd0_err: got err=%b halted=%b want 1/0", error, halted); end
    in_valid = 2'b00;
    tick();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL rd0_sticky: got %b want 1", error); end
  endtask

  task automatic test_mem();
    do_reset();
    set_lane(1, 8);
    in_mem_rmask[1] = 4'hF;
    in_valid = 2'b10;
    tick();
    checks++; if (error !== 1'b0 || mon_mem_rmask[0] !== 4'hF) begin errors++; $display("FAIL mem_read_only: got err=%b rmask=%h want 0/f", error, mon_mem_rmask[0]); end
    in_mem_rmask[1] = 4'h1; in_mem_wmask[1] = 4'h2;
    tick();
    checks++; if (error !== 1'b1 || mon_mem_wmask[0] !== 4'h2) begin errors++; $display("FAIL mem_both: got err=%b wmask=%h want 1/2", error, mon_mem_wmask[0]); end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.order_cnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.order_cnt_q;
    set_lane(0, 20); set_lane(1, 21);
    in_valid = 2'b11;
    tick();
    checks++; if (mon_order[0] !== 64'hFFFF_FFFF_FFFF_FFFE || mon_order[1] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL wrap_order: got %h,%h want fffffffffffffffe,ffffffffffffffff", mon_order[0], mon_order[1]);
    end
    in_valid = 2'b01;
    tick();
    checks++; if (mon_valid !== 8'h01 || mon_order[0] !== 64'd0 || error !== 1'b0) begin
      errors++; $display("FAIL wrap_zero: got valid=%h order=%h err=%b want 01/0/0", mon_valid, mon_order[0], error);
    end
    in_valid = 2'b11;
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++; if (mon_valid !== '0 || mon_order !== '0 || halted !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL async_reset: got valid=%h order0=%0d halted=%b err=%b want 0", mon_valid, mon_order[0], halted, error);
    end
    tick();
    rst = 1'b1;
    set_lane(0, 30); set_lane(1, 31);
    tick();
    checks++; if (mon_valid !== 8'h03 || mon_order[0] !== 64'd0 || mon_inst[1] !== 32'hA000_001F) begin
      errors++; $display("FAIL midstream_restart: got valid=%h order=%0d inst=%h want 03/0/a000001f", mon_valid, mon_order[0], mon_inst[1]);
    end
  endtask

  initial begin
    test_reset();
    test_two_lanes();
    test_compact();
    test_halt();
    test_rd0();
    test_mem();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/rvfi_commit_packer.md
RVFI_COMMIT_PACKER -- requirements
Module: rvfi_commit_packer

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning commit lanes accepted per cycle from the ROB (1..8).
REQ-002 SHALL have parameter CHANNELS, default 8, meaning monitor channels driven (CHANNELS >= LANES).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  [LANES]  commit-lane valid; lane 0 is oldest.
REQ-006 SHALL have port in_inst, in_pc_rdata, in_pc_wdata  input  [LANES][32]  committed instruction, its PC, next PC.
REQ-007 SHALL have port in_rs1_addr, in_rs2_addr, in_rd_addr  input  [LANES][5]  register addresses.
REQ-008 SHALL have port in_rs1_rdata, in_rs2_rdata, in_rd_wdata  input  [LANES][32]  register data.
REQ-009 SHALL have port in_mem_addr, in_mem_rdata, in_mem_wdata  input  [LANES][32]; in_mem_rmask, in_mem_wmask  input  [LANES][4]  memory access record.
REQ-010 SHALL have port mon_*  output  [CHANNELS]  one registered copy of every input field, plus mon_valid [1], mon_order [64], mon_halt [1], matching the monitor channel bundle.
REQ-011 SHALL have port halted  output  1  sticky; a halt has been committed.
REQ-012 SHALL have port error  output  1  sticky protocol error.

Function
REQ-013 SHALL register all mon_* outputs; latency from in_valid to mon_valid is exactly 1 cycle.
REQ-014 SHALL compact valid lanes: the k-th valid input lane (ascending lane index) drives channel k; channels >= popcount(in_valid) drive mon_valid=0.
REQ-015 SHALL assign mon_order[k] = order_cnt + k, where order_cnt is a 64-bit counter of instructions already emitted.
REQ-016 SHALL advance order_cnt by popcount of forwarded lanes each cycle; 64-bit wrap at 2^64-1 to 0 is permitted and is not an error.
REQ-017 SHALL set mon_halt for a forwarded lane when in_pc_wdata == in_pc_rdata (self-loop halt).
REQ-018 SHALL forward lanes older than and including the first halting lane in a cycle; younger lanes in that cycle SHALL be dropped and SHALL set error.
REQ-019 SHALL set halted on the cycle after a halting lane is accepted; once halted, all in_valid lanes are dropped, order_cnt frozen, and any in_valid=1 sets error.
REQ-020 SHALL set error when a forwarded lane has in_rd_addr==0 and in_rd_wdata!=0.
REQ-021 SHALL set error when a forwarded lane has in_mem_rmask!=0 and in_mem_wmask!=0 simultaneously.
REQ-022 SHALL keep mon_valid, mon_halt and mon_order deasserted/zero on cycles with no forwarded lane; data fields of invalid channels are don't-care.
REQ-023 SHALL hold error and halted until reset; neither SHALL clear on its own.

Reset
REQ-024 SHALL, while rst=0, force mon_valid=0, mon_halt=0, mon_order=0, order_cnt=0, halted=0, error=0 immediately, independent of clk.
REQ-025 SHALL on rst deassertion accept in_valid on the first rising edge after release; a lane presented in the cycle of assertion SHALL be discarded.
REQ-026 SHALL tolerate reset mid-stream: after release, the first forwarded instruction has mon_order=0.

Verification
REQ-027 Two lanes valid, no halt, three consecutive cycles -> channels 0,1 valid each cycle, orders 0,1 / 2,3 / 4,5, error=0.
REQ-028 in_valid=2'b10 -> channel 0 carries lane 1 data with order=order_cnt, channel 1 mon_valid=0, counter +1.
REQ-029 Lane 0 pc_rdata=pc_wdata=0x60000040, lane 1 valid -> channel 0 mon_halt=1, lane 1 dropped, error=1, halted=1 next cycle.
REQ-030 After halt, further in_valid=2'b01 -> no mon_valid, order_cnt unchanged, error=1.
REQ-031 Lane with rd_addr=0, rd_wdata=0x00000005 -> forwarded, error=1 next cycle.
REQ-032 Preload order_cnt near 2^64-1 via 2^64-2 forced state, two lanes -> orders 0xFFFF_FFFF_FFFF_FFFE, 0xFFFF_FFFF_FFFF_FFFF, then 0, error=0; assert rst mid-cycle -> outputs zero asynchronously.
